// File: rtl/fifo_drain_checker.sv
// Drain stage behind a parity-protected FIFO18E1: paces reads against a small skid
// buffer, re-checks byte parity and presents words on a valid/ready stream.

module fifo_drain_checker_sva #(
    parameter int LVL_W = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic cap_i,
    input  logic full_i,
    input  logic pop_i,
    input  logic rden_i,
    input  logic empty_i
);
    // A capture may only land in a full buffer when the head leaves at the same edge.
    a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(cap_i && full_i && !pop_i));
    a_no_rderr:    assert property (@(posedge clk) disable iff (rst) !(rden_i && empty_i));
endmodule

module fifo_drain_checker #(
    parameter int RD_LATENCY = 2,
    parameter int BUF_DEPTH  = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             fifo_empty,
    output logic             fifo_rden,
    input  logic [31:0]      fifo_dout,
    input  logic [3:0]       fifo_dop,
    output logic [31:0]      m_data,
    output logic [3:0]       m_perr,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             par_err,
    output logic [CNT_W-1:0] word_count,
    output logic [CNT_W-1:0] err_count,
    output logic             busy
);
    localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int LVL_W = $clog2(BUF_DEPTH + RD_LATENCY + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [RD_LATENCY-1:0] vld_sr_q, vld_sr_d;
    logic [35:0]           buf_q [BUF_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]      occ_q, occ_d;
    logic [LVL_W-1:0]      inflight_s;
    logic                  par_err_q, par_err_d;
    logic [CNT_W-1:0]      word_cnt_q, word_cnt_d;
    logic [CNT_W-1:0]      err_cnt_q, err_cnt_d;
    logic                  cap_s, pop_s, full_s;
    logic [3:0]            cap_perr_s;

    // Bit i flags byte i; the write side stores byte i's parity in dop[3-i].
    function automatic logic [3:0] byte_parity_mismatch(input logic [31:0] d, input logic [3:0] p);
        logic [3:0] m;
        m = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            m[i] = (^d[8*i +: 8]) ^ p[3-i];
        end
        return m;
    endfunction

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Popcount of the read-latency shift register: reads issued but not yet landed.
    always_comb begin
        inflight_s = '0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            inflight_s = inflight_s + LVL_W'(vld_sr_q[i]);
        end
    end

    // No credit for a same-cycle pop keeps the landing guarantee independent of m_ready.
    assign fifo_rden  = (state_q == RUN) && !fifo_empty && ((inflight_s + occ_q) < LVL_W'(BUF_DEPTH));
    assign cap_s      = vld_sr_q[RD_LATENCY-1];
    assign cap_perr_s = byte_parity_mismatch(fifo_dout, fifo_dop);
    assign m_valid    = (occ_q != '0);
    assign pop_s      = m_valid && m_ready;
    assign full_s     = (occ_q == LVL_W'(BUF_DEPTH));
    assign m_data     = buf_q[rd_ptr_q][35:4];
    assign m_perr     = buf_q[rd_ptr_q][3:0];
    assign par_err    = par_err_q;
    assign word_count = word_cnt_q;
    assign err_count  = err_cnt_q;
    assign busy       = (state_q != IDLE);

    // Datapath next-state: latency pipe, pointers, occupancy, error pulse and counters.
    always_comb begin
        vld_sr_d    = '0;
        vld_sr_d[0] = fifo_rden;
        for (int i = 1; i < RD_LATENCY; i++) begin
            vld_sr_d[i] = vld_sr_q[i-1];
        end
        if (cap_s) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d   = ptr_inc(rd_ptr_q);
            word_cnt_d = word_cnt_q + CNT_W'(1);
        end else begin
            rd_ptr_d   = rd_ptr_q;
            word_cnt_d = word_cnt_q;
        end
        case ({cap_s, pop_s})
            2'b10:   occ_d = occ_q + LVL_W'(1);
            2'b01:   occ_d = occ_q - LVL_W'(1);
            default: occ_d = occ_q;
        endcase
        par_err_d = cap_s && (|cap_perr_s);
        if (par_err_d && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + CNT_W'(1);
        end else begin
            err_cnt_d = err_cnt_q;
        end
    end

    // Control FSM next-state; the buffer keeps draining to the stream in every state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (enable) state_d = RUN;
                else        state_d = IDLE;
            end
            RUN: begin
                if (!enable) state_d = FLUSH;
                else         state_d = RUN;
            end
            FLUSH: begin
                if (enable)                                    state_d = RUN;
                else if ((inflight_s == '0) && (occ_q == '0)) state_d = IDLE;
                else                                           state_d = FLUSH;
            end
            default: state_d = IDLE;
        endcase
    end

    // Control and counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            vld_sr_q   <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            occ_q      <= '0;
            par_err_q  <= 1'b0;
            word_cnt_q <= '0;
            err_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            vld_sr_q   <= vld_sr_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            occ_q      <= occ_d;
            par_err_q  <= par_err_d;
            word_cnt_q <= word_cnt_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    // Skid buffer storage: data word with its per-byte mismatch flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                buf_q[i] <= '0;
            end
        end else if (cap_s) begin
            buf_q[wr_ptr_q] <= {fifo_dout, cap_perr_s};
        end
    end

    fifo_drain_checker_sva #(.LVL_W(LVL_W)) u_sva (
        .clk     (clk),
        .rst     (rst),
        .cap_i   (cap_s),
        .full_i  (full_s),
        .pop_i   (pop_s),
        .rden_i  (fifo_rden),
        .empty_i (fifo_empty)
    );
endmodule

// File: tb/tb_fifo_drain_checker.sv
// Scoreboard bench for fifo_drain_checker with a behavioural 2-cycle-latency FIFO model.
module tb_fifo_drain_checker;
    // Narrow counters make wrap and saturation reachable in a short run.
    localparam int TB_CNT_W = 4;

    logic                clk = 1'b0;
    logic                rst, enable, m_ready;
    logic                fifo_empty = 1'b1;
    logic                fifo_rden, m_valid, par_err, busy;
    logic [31:0]         fifo_dout, m_data;
    logic [3:0]          fifo_dop, m_perr;
    logic [TB_CNT_W-1:0] word_count, err_count;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    fifo_drain_checker #(.RD_LATENCY(2), .BUF_DEPTH(4), .CNT_W(TB_CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .fifo_empty (fifo_empty),
        .fifo_rden  (fifo_rden),
        .fifo_dout  (fifo_dout),
        .fifo_dop   (fifo_dop),
        .m_data     (m_data),
        .m_perr     (m_perr),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .par_err    (par_err),
        .word_count (word_count),
        .err_count  (err_count),
        .busy       (busy)
    );

    // FIFO model: a read at edge E shows on DO after the next edge (output register on).
    logic [35:0] fifo_q[$];
    logic [35:0] p0_q = 36'h0, p1_q = 36'h0;
    int          cyc = 0;
    assign fifo_dout = p1_q[35:4];
    assign fifo_dop  = p1_q[3:0];

    always @(posedge clk) begin
        logic [35:0] w;
        cyc <= cyc + 1;
        if (fifo_rden && (fifo_q.size() > 0)) begin
            w = fifo_q.pop_front();
            p0_q <= w;
        end
        p1_q <= p0_q;
        fifo_empty <= (fifo_q.size() == 0);
    end

    logic [35:0] sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] good_dop(input logic [31:0] d);
        return {^d[7:0], ^d[15:8], ^d[23:16], ^d[31:24]};
    endfunction

    // Corrupting dop[j] is reported on byte 3-j.
    task automatic put_word(input logic [31:0] d, input logic [3:0] mask);
        fifo_q.push_back({d, good_dop(d) ^ mask});
        sb.push_back({d, mask[0], mask[1], mask[2], mask[3]});
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor state
    int          total_pops = 0, rden_cnt = 0, rden_bad = 0, perr_pulses = 0;
    int          first_rden = -1, first_valid = -1, first_pop = -1, last_pop = -1, perr_cyc = -1;
    logic        hold_chk_en = 1'b1;
    logic        stall_prev = 1'b0;
    logic [31:0] held_data = 32'h0;

    always @(negedge clk) begin
        logic [35:0] e;
        if (fifo_rden) begin
            rden_cnt++;
            if (fifo_empty) rden_bad++;
            if (first_rden < 0) first_rden = cyc;
        end
        if (par_err) begin
            perr_pulses++;
            if (perr_cyc < 0) perr_cyc = cyc;
        end
        if (m_valid && (first_valid < 0)) first_valid = cyc;
        if (hold_chk_en && stall_prev) begin
            chk("hold_valid", {31'h0, m_valid}, 32'h1);
            chk("hold_data", m_data, held_data);
        end
        stall_prev = hold_chk_en && m_valid && !m_ready;
        held_data  = m_data;
        if (m_valid && m_ready) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL beat_unexpected: got data 0x%0h, expected no beat", m_data);
            end else begin
                e = sb.pop_front();
                chk("beat_data", m_data, e[35:4]);
                chk("beat_perr", {28'h0, m_perr}, {28'h0, e[3:0]});
            end
            total_pops++;
            if (first_pop < 0) first_pop = cyc;
            last_pop = cyc;
        end
    end

    task automatic wait_pops(input int n, input int budget);
        int k;
        k = 0;
        while ((total_pops < n) && (k < budget)) begin
            step(1);
            k++;
        end
        chk("pops_reached", total_pops, n);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; enable = 1'b0; m_ready = 1'b0;
        step(3);
        rst = 1'b0;
        chk("rst_rden", {31'h0, fifo_rden}, 32'h0);
        chk("rst_valid", {31'h0, m_valid}, 32'h0);
        chk("rst_data", m_data, 32'h0);
        chk("rst_perr", {28'h0, m_perr}, 32'h0);
        chk("rst_par_err", {31'h0, par_err}, 32'h0);
        chk("rst_wc", {28'h0, word_count}, 32'h0);
        chk("rst_ec", {28'h0, err_count}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);

        // Enabled with an empty FIFO
        enable = 1'b1; rden_cnt = 0;
        step(6);
        chk("empty_rden_cnt", rden_cnt, 0);
        chk("empty_valid", {31'h0, m_valid}, 32'h0);
        chk("empty_busy", {31'h0, busy}, 32'h1);
        chk("empty_wc", {28'h0, word_count}, 32'h0);

        // 8-word burst, sink always ready
        m_ready = 1'b1; first_rden = -1; first_valid = -1; first_pop = -1; perr_pulses = 0;
        for (int i = 0; i < 8; i++) put_word(32'(i), 4'h0);
        wait_pops(8, 40);
        step(1);
        chk("first_latency", first_valid - first_rden, 3);
        chk("burst_span", last_pop - first_pop, 7);
        chk("burst_wc", {28'h0, word_count}, 32'd8);
        chk("burst_ec", {28'h0, err_count}, 32'd0);
        chk("burst_par_err", perr_pulses, 0);

        // Backpressure: reads stop once four words are owed to the buffer
        m_ready = 1'b0; rden_cnt = 0;
        for (int i = 0; i < 8; i++) put_word(32'hC0DE_0010 + 32'(i), 4'h0);
        step(20);
        chk("bp_rden_cnt", rden_cnt, 4);
        chk("bp_valid", {31'h0, m_valid}, 32'h1);
        chk("bp_head", m_data, 32'hC0DE_0010);
        chk("bp_wc", {28'h0, word_count}, 32'd8);
        m_ready = 1'b1;
        wait_pops(16, 40);
        step(1);
        chk("bp_rden_total", rden_cnt, 8);
        chk("bp_wc_wrap", {28'h0, word_count}, 32'd0);

        // Parity errors, then saturation of err_count
        perr_pulses = 0; first_valid = -1; perr_cyc = -1;
        put_word(32'hA5A5_A5A5, 4'b0100);
        put_word(32'h0102_0304, 4'b1001);
        put_word(32'h1234_5678, 4'b0000);
        wait_pops(19, 40);
        step(1);
        chk("perr_pulses", perr_pulses, 2);
        chk("perr_ec", {28'h0, err_count}, 32'd2);
        chk("perr_align", perr_cyc, first_valid);
        for (int i = 0; i < 14; i++) put_word(32'h5A00_0000 + 32'(i), 4'b0001);
        wait_pops(33, 60);
        step(1);
        chk("sat_ec", {28'h0, err_count}, 32'hF);
        put_word(32'hFFFF_0000, 4'b1111);
        wait_pops(34, 20);
        step(1);
        chk("sat_ec_hold", {28'h0, err_count}, 32'hF);
        chk("sat_pulses", perr_pulses, 17);
        chk("sat_wc", {28'h0, word_count}, 32'd2);

        // Drop enable with two reads in flight
        rden_cnt = 0;
        for (int i = 0; i < 4; i++) put_word(32'hBEEF_0000 + 32'(i), 4'h0);
        step(2);
        enable = 1'b0;
        step(1);
        chk("flush_busy", {31'h0, busy}, 32'h1);
        step(10);
        chk("flush_rden_cnt", rden_cnt, 2);
        chk("flush_delivered", total_pops, 36);
        chk("flush_idle", {31'h0, busy}, 32'h0);
        enable = 1'b1;
        wait_pops(38, 30);
        step(1);
        chk("resume_rden_cnt", rden_cnt, 4);

        // Reset with three words buffered, then word_count wrap from a clean start
        m_ready = 1'b0;
        for (int i = 0; i < 3; i++) put_word(32'h7777_0000 + 32'(i), 4'h0);
        step(8);
        chk("prerst_valid", {31'h0, m_valid}, 32'h1);
        hold_chk_en = 1'b0;
        step(1);
        rst = 1'b1;
        sb.delete();
        step(1);
        rst = 1'b0;
        chk("mrst_valid", {31'h0, m_valid}, 32'h0);
        chk("mrst_wc", {28'h0, word_count}, 32'h0);
        chk("mrst_ec", {28'h0, err_count}, 32'h0);
        chk("mrst_busy", {31'h0, busy}, 32'h0);
        hold_chk_en = 1'b1;
        m_ready = 1'b1;
        for (int i = 0; i < 15; i++) put_word(32'h3000_0000 + 32'(i), 4'h0);
        wait_pops(53, 40);
        step(1);
        chk("wrap_wc_max", {28'h0, word_count}, 32'hF);
        put_word(32'h3000_00FF, 4'h0);
        wait_pops(54, 20);
        step(1);
        chk("wrap_wc_zero", {28'h0, word_count}, 32'h0);
        chk("rden_while_empty", rden_bad, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule

// File: doc/fifo_drain_checker.md
# fifo_drain_checker

Read-side drain stage placed directly downstream of the 32-bit + 4-parity FIFO18E1 buffer (standard mode, output register enabled, 2-cycle read latency). Issues `fifo_rden` only when the FIFO is non-empty and landing space is guaranteed. Captures returning words into a small skid buffer, re-checks per-byte parity against `fifo_dop`, and presents words on a valid/ready stream with error flags and counters.

## Interface
- `RD_LATENCY`, 2: cycles from `fifo_rden` high to data valid on `fifo_dout`/`fifo_dop`; legal range 1..3.
- `BUF_DEPTH`, 4: skid buffer entries; must be ≥ RD_LATENCY+2.
- `CNT_W`, 16: width of `word_count` and `err_count`.

Ports:
- `clk` in 1: the single clock; the FIFO's RDCLK and WRCLK are driven from it.
- `rst` in 1: synchronous, active-high reset.
- `enable` in 1: permits new FIFO reads.
- `fifo_empty` in 1: FIFO EMPTY flag.
- `fifo_rden` out 1: FIFO read enable.
- `fifo_dout` in 32: FIFO DO.
- `fifo_dop` in 4: FIFO DOP.
- `m_data` out 32: stream data (buffer head).
- `m_perr` out 4: per-byte parity mismatch for `m_data`; bit i covers byte i.
- `m_valid` out 1: stream valid.
- `m_ready` in 1: stream ready.
- `par_err` out 1: one-cycle pulse when a mismatching word is captured.
- `word_count` out CNT_W: words accepted downstream; wraps.
- `err_count` out CNT_W: words captured with any mismatch; saturates at all-ones.
- `busy` out 1: high when state ≠ IDLE.

## Operation
- Parity convention (write side): `dop[3]`=^din[7:0], `dop[2]`=^din[15:8], `dop[1]`=^din[23:16], `dop[0]`=^din[31:24], even parity per byte. Check: `m_perr[i]` = (^byte i) XOR `dop[3-i]`.
- Issue rule, combinational, current registered values only: `fifo_rden` = state==RUN && !`fifo_empty` && (inflight + occupancy < BUF_DEPTH). No credit is taken for a same-cycle pop.
- In-flight tracking: RD_LATENCY-deep valid shift register fed by `fifo_rden`; its output is the capture strobe. `inflight` = popcount of the shift register.
- Capture: on strobe, write {`fifo_dout`, computed mismatch} into the circular buffer at `wr_ptr`. Pointers wrap modulo BUF_DEPTH. The issue rule guarantees no overflow; capture into a full buffer is an assertion failure.
- Pop on `m_valid && m_ready`; `word_count`++ on each pop.
- Simultaneous capture and pop: occupancy unchanged. Legal at every occupancy, including full with the pop freeing the slot.
- `m_valid`/`m_data`/`m_perr` are held stable while `m_valid && !m_ready`.
- FSM:
  - IDLE → RUN when `enable`.
  - RUN → FLUSH when `!enable`; `fifo_rden` is low in FLUSH.
  - FLUSH → IDLE when inflight==0 and occupancy==0.
  - FLUSH → RUN if `enable` returns.
  - The buffer continues draining to the stream in every state.

## Timing
- Reset values: state IDLE; `fifo_rden` 0, `m_valid` 0, `m_data` 0, `m_perr` 0, `par_err` 0, both counters 0, `busy` 0, pointers/occupancy/shift register cleared.
- Reset mid-operation discards in-flight and buffered words; those words are lost because the FIFO pointer has already advanced. This is accepted behaviour.
- `fifo_rden` high in cycle N → capture at the edge ending cycle N+RD_LATENCY → `m_valid` high in cycle N+RD_LATENCY+1. With defaults: first word 3 cycles after `fifo_rden`.
- `par_err` is high in cycle N+RD_LATENCY+1, aligned with that word entering the buffer. `err_count` updates at the same edge.
- Throughput: 1 word/cycle sustained with `m_ready` held high and FIFO non-empty.
- `fifo_rden` is never high while `fifo_empty` is high, so FIFO RDERR never fires.

## Test plan
- Reset, then `enable`=1 with FIFO empty: `fifo_rden` stays 0, `m_valid` 0, `busy` 1; counters 0.
- Write 8 words 0x00000000..0x00000007 with correct parity, `m_ready`=1: first `m_valid` 3 cycles after first `fifo_rden`; 8 consecutive beats in order; `word_count`=8; `err_count`=0; `par_err` never pulses.
- 8 words, `m_ready`=0 for 20 cycles then 1: `fifo_rden` pulses exactly 4 times, then stops (inflight+occupancy=4); no overflow; order preserved; then all 8 words drain with `word_count`=8.
- Inject `dop` byte-1 error on word 0xA5A5A5A5: `m_perr`=4'b0010 on that beat; one `par_err` pulse; `err_count`=1. Preset `err_count` to 0xFFFF → stays 0xFFFF after the next error.
- Drop `enable` with 2 reads in flight: no further `fifo_rden`; both words delivered; FSM goes FLUSH → IDLE and `busy` falls after the last pop.
- Assert `rst` for 1 cycle with 3 words buffered: next cycle `m_valid`=0, counters=0, state IDLE; `word_count` wraps 0xFFFF → 0x0000 on the following pop.
